// File: rtl/debounce_pulse.sv
// debounce_pulse: Moore debouncer emitting a clean level and one rising-edge pulse; DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer
module debounce_pulse #(
  parameter int STABLE = 4,
  parameter int W = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic level
);
  typedef enum logic [2:0] {LOW, RISE_WAIT, PULSE, HIGH, FALL_WAIT} state_t;
  localparam logic [W-1:0] LAST = W'(STABLE - 1);
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic x;
`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clock)
    sync <= reset ? 2'b00 : {sync[0], in};
  assign x = sync[1];
`else
  assign x = in;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOW;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      LOW: if (x) begin
        state_n = RISE_WAIT;
        cnt_n = '0;
      end
      RISE_WAIT: if (!x) begin
        state_n = LOW;
        cnt_n = '0;
      end else if (cnt == LAST) state_n = PULSE;
      else cnt_n = cnt + 1'b1;
      PULSE: state_n = HIGH;
      HIGH: if (!x) begin
        state_n = FALL_WAIT;
        cnt_n = '0;
      end
      FALL_WAIT: if (x) begin
        state_n = HIGH;
        cnt_n = '0;
      end else if (cnt == LAST) begin
        state_n = LOW;
        cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
      default: begin
        state_n = LOW;
        cnt_n = '0;
      end
    endcase
  end
  assign out = state == PULSE;
  assign level = state == PULSE || state == HIGH || state == FALL_WAIT;
endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: sliding-window reference model feeding a scoreboard queue, checked each cycle by a monitor
module tb_debounce_pulse;
  localparam int STABLE = 4;
  localparam int W = 3;
  typedef struct packed {logic o; logic l; logic [1:0] c;} exp_t;
  logic clock, reset, in, out, level;
  logic [1:0] presses;
  exp_t q[$];
  int tests = 0, fails = 0;
  debounce_pulse #(.STABLE(STABLE), .W(W)) dut (
    .clock(clock), .reset(reset), .in(in), .out(out), .level(level)
  );
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  always_ff @(posedge clock)
    presses <= reset ? 2'd0 : presses + {1'b0, out};
  logic m_l = 0, m_skip = 0, m_pulse = 0, m_x, s0 = 0, s1 = 0, all_new;
  logic [1:0] m_c = 0;
  logic hist[$];
  always @(posedge clock) begin
`ifdef DEBOUNCE_SYNC_EN
    m_x = s1;
    s1 = reset ? 1'b0 : s0;
    s0 = reset ? 1'b0 : in;
`else
    m_x = in;
`endif
    m_pulse = 0;
    if (reset) begin
      m_l = 0;
      m_skip = 0;
      m_c = 0;
      hist.delete();
    end else if (m_skip) begin
      m_skip = 0;
      m_c = m_c + 2'd1;
    end else begin
      hist.push_back(m_x);
      if (hist.size() > STABLE + 1) void'(hist.pop_front());
      all_new = hist.size() == STABLE + 1;
      foreach (hist[i]) if (hist[i] == m_l) all_new = 0;
      if (all_new) begin
        m_l = !m_l;
        hist.delete();
        m_pulse = m_l;
        m_skip = m_l;
      end
    end
    q.push_back('{o: m_pulse, l: m_l, c: m_c});
  end
  exp_t e;
  always @(negedge clock) begin
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL queue: no expectation at %0t", $time);
    end else begin
      e = q.pop_front();
      tests += 3;
      if (out !== e.o) begin
        fails++;
        $display("FAIL out at %0t: got %b want %b", $time, out, e.o);
      end
      if (level !== e.l) begin
        fails++;
        $display("FAIL level at %0t: got %b want %b", $time, level, e.l);
      end
      if (presses !== e.c) begin
        fails++;
        $display("FAIL count at %0t: got %0d want %0d", $time, presses, e.c);
      end
    end
  end
  task automatic drive(input logic r, input logic i, input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
      reset = r;
      in = i;
    end
  endtask
  initial begin
    logic [9:0] bounce;
    reset = 1;
    in = 0;
    drive(1, 1, 2);
    drive(0, 0, 8);
    drive(0, 1, 20);
    drive(0, 0, 10);
    bounce = 10'b1011011111;
    for (int i = 9; i >= 0; i--) drive(0, bounce[i]);
    drive(0, 1, 5);
    drive(0, 0, 3);
    drive(0, 1);
    drive(0, 0, 10);
    drive(0, 1, 10);
    drive(0, 0, 10);
    repeat (4) begin
      drive(0, 1, 8);
      drive(0, 0, 8);
    end
    drive(0, 1, STABLE + 1);
    drive(1, 1);
    drive(0, 1, 12);
    drive(0, 0, 10);
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(1, 8));
    end
    drive(0, 0, 3);
    @(negedge clock);
    @(negedge clock);
    tests++;
    if (q.size() > 1) begin
      fails++;
      $display("FAIL drain: got %0d pending want <=1", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
